// File: rtl/and_vector_checker.sv
// rtl/and_vector_checker.sv - on-chip self-check for an a/b/c two-input AND stream
//
// Purpose
//   Receives (a, b, c) vectors over a valid/ready handshake. Each accepted vector
//   is checked for c == a & b. A run consists of NUM_VECTORS accepted vectors.
//   During a run the checker counts the accepted vectors and the mismatches, and
//   it records the index of the first mismatch. When the run ends it reports
//   done and pass.
//
// Ports
//   clk            in   1          rising-edge clock
//   rst            in   1          synchronous reset, active-high
//   start          in   1          one-cycle pulse, starts a run from IDLE or DONE
//   in_valid       in   1          a vector is present on in_a/in_b/in_c
//   in_ready       out  1          the checker accepts a vector this cycle (RUN only)
//   in_a           in   1          operand a
//   in_b           in   1          operand b
//   in_c           in   1          observed result for (in_a, in_b)
//   err_pulse      out  1          one-cycle flag raised after a bad vector is accepted
//   err_cnt        out  CNT_WIDTH  saturating mismatch count of the current/last run
//   vec_cnt        out  IDX_W      accepted vectors in the current/last run
//   first_err_idx  out  IDX_W      0-based index of the first mismatch (valid if err_cnt != 0)
//   busy           out  1          high in RUN
//   done           out  1          high in DONE
//   pass           out  1          done and no mismatches

module and_vector_checker #(
   parameter int NUM_VECTORS = 100,
   parameter int CNT_WIDTH   = 8,
   localparam int IDX_W      = $clog2(NUM_VECTORS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_a,
   input  logic                 in_b,
   input  logic                 in_c,
   output logic                 err_pulse,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic [IDX_W-1:0]     vec_cnt,
   output logic [IDX_W-1:0]     first_err_idx,
   output logic                 busy,
   output logic                 done,
   output logic                 pass
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Value of vec_cnt just before the final accept of a run.
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_VECTORS - 1);
   localparam logic [CNT_WIDTH-1:0] ERR_MAX  = {CNT_WIDTH{1'b1}};

   state_t state;
   state_t state_next;

   logic accept;
   logic mismatch;
   logic start_run;
   logic last_accept;

   // Handshake and check decode
   assign in_ready    = (state == ST_RUN);
   assign accept      = in_valid && in_ready;
   assign mismatch    = in_c != (in_a & in_b);
   assign last_accept = accept && (vec_cnt == LAST_IDX);

   // A start seen in RUN is ignored, so only IDLE and DONE can begin a new run.
   assign start_run   = start && (state != ST_RUN);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start_run) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_accept) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start_run) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign pass = done && (err_cnt == '0);

   // Result counters. Clearing happens on the start edge itself, so the first
   // RUN cycle already shows zeroed counts. The check result of the vector
   // accepted at an edge appears after that edge, which gives a latency of one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_pulse     <= 1'b0;
         err_cnt       <= '0;
         vec_cnt       <= '0;
         first_err_idx <= '0;
      end else begin
         err_pulse <= accept && mismatch;
         if (start_run) begin
            err_cnt       <= '0;
            vec_cnt       <= '0;
            first_err_idx <= '0;
         end else if (accept) begin
            vec_cnt <= vec_cnt + 1'b1;
            if (mismatch) begin
               if (err_cnt != ERR_MAX) begin
                  err_cnt <= err_cnt + 1'b1;
               end
               // Index is captured before the increment of vec_cnt, so it is 0-based.
               if (err_cnt == '0) begin
                  first_err_idx <= vec_cnt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_and_vector_checker.sv
// tb/tb_and_vector_checker.sv - directed, table-driven bench for and_vector_checker

module tb_and_vector_checker;

   localparam int N = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_a;
   logic       in_b;
   logic       in_c;

   logic       in_ready;
   logic       err_pulse;
   logic [7:0] err_cnt;
   logic [6:0] vec_cnt;
   logic [6:0] first_err_idx;
   logic       busy;
   logic       done;
   logic       pass;

   logic       s_in_ready;
   logic       s_err_pulse;
   logic [1:0] s_err_cnt;
   logic [6:0] s_vec_cnt;
   logic [6:0] s_first_err_idx;
   logic       s_busy;
   logic       s_done;
   logic       s_pass;

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;

   always #5 clk = ~clk;

   and_vector_checker #(.NUM_VECTORS(N), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .err_pulse(err_pulse), .err_cnt(err_cnt),
      .vec_cnt(vec_cnt), .first_err_idx(first_err_idx), .busy(busy), .done(done), .pass(pass)
   );

   // Second instance with a 2-bit error counter, driven by the same stimulus.
   and_vector_checker #(.NUM_VECTORS(N), .CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
      .vec_cnt(s_vec_cnt), .first_err_idx(s_first_err_idx), .busy(s_busy), .done(s_done),
      .pass(s_pass)
   );

   always @(negedge clk) begin
      if (err_pulse === 1'b1) pulse_cnt++;
   end

   typedef struct {
      logic a;
      logic b;
      logic c;
      int   exp_pulse;
      int   exp_err;
      int   exp_vec;
      int   exp_first;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // One accepted vector. in_ready is high in RUN, so the vector is taken at the next edge.
   task automatic send(input logic a, input logic b, input logic c);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_c = c;
      tick();
      in_valid = 1'b0;
   endtask

   // Send vectors with indices base..base+n-1 and random a/b. The value of c is
   // inverted at indices bad1 and bad2. When step > 0 it is also inverted where idx % step == 3.
   task automatic run_vecs(input int base, input int n, input int bad1, input int bad2,
                           input int step);
      for (int i = 0; i < n; i++) begin
         int  idx;
         logic a, b, bad;
         idx = base + i;
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         bad = (idx == bad1) || (idx == bad2) || (step > 0 && (idx % step) == 3);
         send(a, b, (a & b) ^ bad);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_a = 1'b0;
      in_b = 1'b0;
      in_c = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_vec_cnt", vec_cnt, 0);
      rst = 1'b0;
      tick();

      // Vectors offered in IDLE are dropped
      in_valid = 1'b1; in_a = 1'b1; in_b = 1'b0; in_c = 1'b1;
      tick();
      in_valid = 1'b0;
      check("idle_drop_vec", vec_cnt, 0);
      check("idle_drop_err", err_cnt, 0);

      // Run 1: a clean run of 100 vectors
      pulse_start();
      check("start_busy", busy, 1);
      check("start_ready", in_ready, 1);
      run_vecs(0, N, -1, -1, 0);
      check("r1_done", done, 1);
      check("r1_pass", pass, 1);
      check("r1_err", err_cnt, 0);
      check("r1_vec", vec_cnt, N);
      check("r1_ready", in_ready, 0);
      check("r1_busy", busy, 0);

      // Run 2: the table run. It checks each of the first 8 vectors and then completes the run.
      tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 0, 0, 2, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1, 1, 3, 2};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 0, 1, 4, 2};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1, 2, 5, 2};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1, 3, 6, 2};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 0, 3, 7, 2};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 1, 4, 8, 2};
      pulse_start();
      check("r2_cleared_vec", vec_cnt, 0);
      check("r2_cleared_done", done, 0);
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].c);
         check($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].exp_pulse);
         check($sformatf("tbl%0d_err", i), err_cnt, tbl[i].exp_err);
         check($sformatf("tbl%0d_vec", i), vec_cnt, tbl[i].exp_vec);
         if (tbl[i].exp_err != 0)
            check($sformatf("tbl%0d_first", i), first_err_idx, tbl[i].exp_first);
      end
      run_vecs(8, N - 8, -1, -1, 0);
      check("r2_done", done, 1);
      check("r2_err", err_cnt, 4);
      check("r2_pass", pass, 0);

      // Run 3: errors at indices 5 and 42, including the mid-run err_pulse
      pulse_start();
      pulse_cnt = 0;
      run_vecs(0, N, 5, 42, 0);
      tick();
      check("r3_pulses", pulse_cnt, 2);
      check("r3_err", err_cnt, 2);
      check("r3_first", first_err_idx, 5);
      check("r3_pass", pass, 0);
      check("r3_done", done, 1);

      // Run 4: error on the final vector. err_pulse still fires after DONE is entered.
      pulse_start();
      run_vecs(0, N - 1, -1, -1, 0);
      send(1'b1, 1'b1, 1'b0);
      check("r4_last_pulse", err_pulse, 1);
      check("r4_last_done", done, 1);
      check("r4_last_first", first_err_idx, N - 1);
      tick();
      check("r4_pulse_clears", err_pulse, 0);

      // Run 5: 10 bad vectors (idx%10==3). The 2-bit counter saturates at 3.
      pulse_start();
      run_vecs(0, N, -1, -1, 10);
      check("r5_err8", err_cnt, 10);
      check("r5_sat_err", s_err_cnt, 3);
      check("r5_sat_first", s_first_err_idx, 3);
      check("r5_sat_done", s_done, 1);
      check("r5_sat_pass", s_pass, 0);

      // Run 6: in_valid toggles randomly. Exactly 100 accepts occur, and extras are ignored.
      pulse_start();
      begin
         int acc = 0;
         int cyc = 0;
         while (acc < N && cyc < 2000) begin
            logic a, b, v;
            v = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            in_valid = v; in_a = a; in_b = b; in_c = a & b;
            if (v && in_ready) acc++;
            tick();
            cyc++;
         end
         in_valid = 1'b0;
         check("r6_bound", acc, N);
         check("r6_vec", vec_cnt, N);
         check("r6_done", done, 1);
         check("r6_ready", in_ready, 0);
         for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b1);
         check("r6_extra_vec", vec_cnt, N);
         check("r6_extra_err", err_cnt, 0);
         check("r6_pass", pass, 1);
      end

      // Run 7: reset after 37 accepts, then a full run
      pulse_start();
      run_vecs(0, 37, 2, -1, 0);
      check("r7_vec37", vec_cnt, 37);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("r7_rst_vec", vec_cnt, 0);
      check("r7_rst_err", err_cnt, 0);
      check("r7_rst_first", first_err_idx, 0);
      check("r7_rst_busy", busy, 0);
      check("r7_rst_ready", in_ready, 0);
      check("r7_rst_pulse", err_pulse, 0);
      pulse_start();
      run_vecs(0, N, -1, -1, 0);
      check("r7_full_vec", vec_cnt, N);
      check("r7_full_pass", pass, 1);

      // Run 8: start mid-RUN is ignored
      pulse_start();
      run_vecs(0, 20, 4, -1, 0);
      start = 1'b1;
      send(1'b0, 1'b1, 1'b0);
      start = 1'b0;
      check("r8_mid_vec", vec_cnt, 21);
      check("r8_mid_err", err_cnt, 1);
      check("r8_mid_busy", busy, 1);
      run_vecs(21, N - 21, -1, -1, 0);
      check("r8_done", done, 1);
      check("r8_vec", vec_cnt, N);
      check("r8_first", first_err_idx, 4);

      // A start in DONE clears the counts and begins a new run
      pulse_start();
      check("r8_restart_vec", vec_cnt, 0);
      check("r8_restart_err", err_cnt, 0);
      check("r8_restart_busy", busy, 1);

      // rst overrides a coincident start
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      tick();
      check("rst_start_busy", busy, 0);
      check("rst_start_ready", in_ready, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
